// File: rtl/note_scheduler.sv
// Buzzer note scheduler: free play from a one-hot switch note, or autoplay of a
// song ROM (note, beats) with a timed silence between notes.
module note_scheduler #(
   parameter int TICK_DIV = 100000,
   parameter int BEAT_MS  = 250,
   parameter int GAP_MS   = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mode_auto,
   input  logic        start,
   input  logic        stop,
   input  logic [20:0] manual_note,
   output logic [7:0]  song_addr,
   input  logic [4:0]  song_note,
   input  logic [3:0]  song_dur,
   output logic [20:0] buzzer_note,
   output logic        busy,
   output logic        done
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MS_MAX = (BEAT_MS > GAP_MS) ? BEAT_MS : GAP_MS;
   localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [MS_W-1:0]   BEAT_LAST = MS_W'(BEAT_MS - 1);
   localparam logic [MS_W-1:0]   GAP_LAST  = MS_W'(GAP_MS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP, DONE} StateT;

   StateT             r_state;
   StateT             w_nextState;
   logic [TICK_W-1:0] r_tickCnt;
   logic [MS_W-1:0]   r_msCnt;
   logic [3:0]        r_beatCnt;
   logic [4:0]        r_note;
   logic [3:0]        r_dur;
   logic [7:0]        r_songAddr;
   logic [20:0]       r_buzzer;
   logic [20:0]       w_buzzerNext;
   logic              w_msTick;
   logic              w_inSong;
   logic              w_manualOneHot;

   function automatic logic [20:0] noteOneHot(input logic [4:0] idx);
      if (idx >= 5'd1 && idx <= 5'd21)
         return 21'd1 << (idx - 5'd1);
      return '0;
   endfunction

   assign w_msTick       = (r_tickCnt == TICK_LAST);
   assign w_inSong       = (r_state inside {FETCH, LATCH, PLAY, GAP});
   assign w_manualOneHot = (manual_note != '0) && ((manual_note & (manual_note - 21'd1)) == '0);
   assign song_addr      = r_songAddr;
   assign buzzer_note    = r_buzzer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_tickCnt <= '0;
      else if (w_msTick)
         r_tickCnt <= '0;
      else
         r_tickCnt <= r_tickCnt + TICK_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:  if (start && mode_auto && !stop) w_nextState = FETCH;
         FETCH: w_nextState = LATCH;
         LATCH: w_nextState = (song_dur == 4'd0) ? DONE : PLAY;
         PLAY:  if (w_msTick && r_msCnt == BEAT_LAST && r_beatCnt == r_dur - 4'd1)
                   w_nextState = GAP;
         GAP:   if (w_msTick && r_msCnt == GAP_LAST)
                   w_nextState = (r_songAddr == 8'hFF) ? DONE : FETCH;
         DONE:  w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
      if (w_inSong && (stop || !mode_auto))
         w_nextState = IDLE;
   end

   // The buzzer register follows the next state, so it lines up with PLAY exactly.
   always_comb begin
      busy         = w_inSong;
      done         = (r_state == DONE);
      w_buzzerNext = '0;
      if (w_nextState == PLAY)
         w_buzzerNext = noteOneHot((r_state == LATCH) ? song_note : r_note);
      else if (r_state == IDLE && w_nextState == IDLE && !mode_auto && w_manualOneHot)
         w_buzzerNext = manual_note;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_buzzer <= '0;
      else
         r_buzzer <= w_buzzerNext;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_note <= '0;
         r_dur  <= '0;
      end else if (r_state == LATCH) begin
         r_note <= song_note;
         r_dur  <= song_dur;
      end
   end

   // Counters restart on every state change; PLAY rolls ms into beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msCnt   <= '0;
         r_beatCnt <= '0;
      end else if (w_nextState != r_state) begin
         r_msCnt   <= '0;
         r_beatCnt <= '0;
      end else if (w_msTick && (r_state == PLAY || r_state == GAP)) begin
         if (r_state == PLAY && r_msCnt == BEAT_LAST) begin
            r_msCnt   <= '0;
            r_beatCnt <= r_beatCnt + 4'd1;
         end else begin
            r_msCnt <= r_msCnt + MS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_songAddr <= '0;
      else if (r_state == GAP && w_nextState == FETCH)
         r_songAddr <= r_songAddr + 8'd1;
      else if (w_nextState == IDLE || r_state == IDLE)
         r_songAddr <= '0;
   end

endmodule

// File: tb/tb_note_scheduler.sv
// Randomized bench for note_scheduler: a timeline model predicts every output
// cycle by cycle from the song ROM contents and the ms tick schedule.
module tb_note_scheduler;

   localparam int TICK_DIV = 4;
   localparam int BEAT_MS  = 2;
   localparam int GAP_MS   = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mode_auto = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [20:0] manual_note = '0;
   logic [7:0]  song_addr;
   logic [4:0]  song_note = '0;
   logic [3:0]  song_dur = '0;
   logic [20:0] buzzer_note;
   logic        busy;
   logic        done;

   note_scheduler #(.TICK_DIV(TICK_DIV), .BEAT_MS(BEAT_MS), .GAP_MS(GAP_MS)) dut (
      .clk(clk), .rst(rst), .mode_auto(mode_auto), .start(start), .stop(stop),
      .manual_note(manual_note), .song_addr(song_addr), .song_note(song_note),
      .song_dur(song_dur), .buzzer_note(buzzer_note), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [4:0] romNote [256];
   logic [3:0] romDur  [256];

   always @(posedge clk) begin
      song_note <= romNote[song_addr];
      song_dur  <= romDur[song_addr];
   end

   typedef struct {
      int          cyc;
      logic [20:0] buzz;
      logic        busy;
      logic        done;
      logic [7:0]  addr;
      logic        gap;
   } ExpT;

   ExpT         expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [20:0] idleBuzz = '0;
   logic        curFromQ = 1'b0;
   logic        curBusy = 1'b0;
   logic        curGap = 1'b0;
   int          doneSeen = 0;
   logic        seenNonZero = 1'b0;
   logic        wrapSeen = 1'b0;
   int          maxAddr = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, observed, expected);
      end
   endtask

   function automatic logic [20:0] noteHot(input int n);
      logic [20:0] one;
      one = 21'd1;
      if (n >= 1 && n <= 21)
         return one << (n - 1);
      return '0;
   endfunction

   // Cycle in which the n-th ms tick at or after cycle 'from' occurs.
   function automatic int tickEnd(input int from, input int n);
      int first;
      first = from + (TICK_DIV - 1 - (from % TICK_DIV));
      return first + (n - 1) * TICK_DIV;
   endfunction

   task automatic pushExp(input int c, input logic [20:0] b, input logic bs, input logic dn,
                          input int a, input logic g);
      ExpT e;
      e.cyc = c; e.buzz = b; e.busy = bs; e.done = dn; e.addr = 8'(a); e.gap = g;
      expQ.push_back(e);
   endtask

   // Expected timeline of a whole song whose start is sampled at the end of cycle s.
   task automatic buildSong(input int s);
      int c;
      int a;
      int t;
      c = s + 1;
      a = 0;
      while (1) begin
         pushExp(c, '0, 1'b1, 1'b0, a, 1'b0);
         pushExp(c + 1, '0, 1'b1, 1'b0, a, 1'b0);
         c += 2;
         if (romDur[a] == 4'd0) begin
            pushExp(c, '0, 1'b0, 1'b1, a, 1'b0);
            break;
         end
         t = tickEnd(c, int'(romDur[a]) * BEAT_MS);
         for (int k = c; k <= t; k++) pushExp(k, noteHot(int'(romNote[a])), 1'b1, 1'b0, a, 1'b0);
         c = t + 1;
         t = tickEnd(c, GAP_MS);
         for (int k = c; k <= t; k++) pushExp(k, '0, 1'b1, 1'b0, a, 1'b1);
         c = t + 1;
         if (a == 255) begin
            pushExp(c, '0, 1'b0, 1'b1, a, 1'b0);
            break;
         end
         a++;
      end
   endtask

   task automatic compareCycle();
      ExpT         e;
      logic [20:0] eBuzz;
      logic        eBusy;
      logic        eDone;
      logic [7:0]  eAddr;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
         e = expQ.pop_front();
         eBuzz = e.buzz; eBusy = e.busy; eDone = e.done; eAddr = e.addr;
         curFromQ = 1'b1; curBusy = e.busy; curGap = e.gap;
      end else begin
         eBuzz = idleBuzz; eBusy = 1'b0; eDone = 1'b0; eAddr = '0;
         curFromQ = 1'b0; curBusy = 1'b0; curGap = 1'b0;
      end
      checkOutput("buzzer_note", 32'(buzzer_note), 32'(eBuzz));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("song_addr", 32'(song_addr), 32'(eAddr));
      if (done === 1'b1) doneSeen++;
      if (busy === 1'b1) begin
         if (song_addr != 8'd0) seenNonZero = 1'b1;
         else if (seenNonZero) wrapSeen = 1'b1;
         if (int'(song_addr) > maxAddr) maxAddr = int'(song_addr);
      end
   endtask

   task automatic applyStimulus(input logic iStart, input logic iStop, input logic iMode,
                                input logic [20:0] iManual);
      start = iStart; stop = iStop; mode_auto = iMode; manual_note = iManual;
      if (curBusy && (iStop || !iMode))
         expQ.delete();
      else if (!curFromQ && iStart && iMode && !iStop)
         buildSong(cyc);
      idleBuzz = (!curFromQ && !iMode && $onehot(iManual)) ? iManual : '0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compareCycle();
   endtask

   task automatic doReset();
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      #1;
      checkOutput("rst buzzer_note", 32'(buzzer_note), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst song_addr", 32'(song_addr), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      expQ.delete();
      idleBuzz = '0;
      compareCycle();
   endtask

   task automatic loadSimpleSong();
      for (int i = 0; i < 256; i++) begin romNote[i] = 5'd0; romDur[i] = 4'd0; end
      romNote[0] = 5'd3; romDur[0] = 4'd1;
      romNote[1] = 5'd0; romDur[1] = 4'd2;
   endtask

   task automatic runToIdle(input int maxCycles, input logic [20:0] watchNote, output int runLen);
      int n;
      n = 0;
      runLen = 0;
      while ((curFromQ || expQ.size() > 0) && n < maxCycles) begin
         applyStimulus(1'b0, 1'b0, 1'b1, '0);
         if (buzzer_note === watchNote) runLen++;
         n++;
      end
      if (n >= maxCycles) checkOutput("song end timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          runLen;
      int          doneBefore;
      int          n;
      logic        modeR;
      logic [20:0] man;
      logic [20:0] one;
      one = 21'd1;
      for (int i = 0; i < 256; i++) begin romNote[i] = 5'd0; romDur[i] = 4'd0; end
      #2;
      doReset();

      // Free play
      applyStimulus(1'b0, 1'b0, 1'b0, 21'h000004);
      checkOutput("free one-hot", 32'(buzzer_note), 32'h4);
      applyStimulus(1'b0, 1'b0, 1'b0, 21'h000006);
      checkOutput("free two bits", 32'(buzzer_note), 32'h0);
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: man = one << $urandom_range(0, 20);
            1: man = 21'($urandom);
            default: man = '0;
         endcase
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'b0, 1'b0, man);
      end

      // Song with the PLAY phase aligned so the first note spans two full ticks
      loadSimpleSong();
      while (cyc % TICK_DIV != 1) applyStimulus(1'b0, 1'b0, 1'b1, '0);
      doneBefore = doneSeen;
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      runToIdle(200, 21'h000004, runLen);
      checkOutput("song note length", 32'(runLen), 32'd8);
      checkOutput("song done pulses", 32'(doneSeen - doneBefore), 32'd1);
      checkOutput("song busy after", 32'(busy), 32'd0);

      // Abort mid-PLAY with stop
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      n = 0;
      while (buzzer_note == '0 && n < 50) begin
         applyStimulus(1'b0, 1'b0, 1'b1, '0);
         n++;
      end
      doneBefore = doneSeen;
      applyStimulus(1'b0, 1'b1, 1'b1, '0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort buzzer", 32'(buzzer_note), 32'd0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
      checkOutput("abort no done", 32'(doneSeen - doneBefore), 32'd0);

      // Start and stop together in IDLE
      applyStimulus(1'b1, 1'b1, 1'b1, '0);
      checkOutput("collision busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0);

      // Dropping mode_auto mid-song, then free play resumes
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, 21'h000010);
      checkOutput("mode drop buzzer", 32'(buzzer_note), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 21'h000010);
      checkOutput("mode drop free", 32'(buzzer_note), 32'h10);

      // Full ROM: the song must stop after address 255
      for (int i = 0; i < 256; i++) begin romNote[i] = 5'd1; romDur[i] = 4'd1; end
      seenNonZero = 1'b0; wrapSeen = 1'b0; maxAddr = 0;
      doneBefore = doneSeen;
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      runToIdle(6000, 21'h000001, runLen);
      checkOutput("wrap done pulses", 32'(doneSeen - doneBefore), 32'd1);
      checkOutput("wrap addr to zero", 32'(wrapSeen), 32'd0);
      checkOutput("wrap max addr", 32'(maxAddr), 32'd255);

      // Reset during GAP, then a fresh replay
      loadSimpleSong();
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      n = 0;
      while (!curGap && n < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b1, '0);
         n++;
      end
      checkOutput("reached gap", 32'(curGap), 32'd1);
      doneBefore = doneSeen;
      doReset();
      checkOutput("reset no done", 32'(doneSeen - doneBefore), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      checkOutput("replay addr", 32'(song_addr), 32'd0);
      runToIdle(200, 21'h000004, runLen);
      checkOutput("replay done pulses", 32'(doneSeen - doneBefore), 32'd1);

      // Random traffic against the timeline model
      modeR = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (!curFromQ && expQ.size() == 0 && $urandom_range(0, 99) == 0) begin
            for (int k = 0; k < 256; k++) begin
               romNote[k] = 5'($urandom_range(0, 31));
               romDur[k]  = 4'($urandom_range(0, 3));
            end
         end
         if ($urandom_range(0, 59) == 0) modeR = ~modeR;
         man = ($urandom_range(0, 1) == 1) ? (one << $urandom_range(0, 20)) : 21'($urandom);
         applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 79) == 0), modeR, man);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
